// File: rtl/cpu_step_controller.sv
// cpu_step_controller: single-cycle clock-enable generator for the 8-bit core.
// Samples the divided slow_clk on clk_in and issues cpu_ce in RUN, STEP or HALT.
// Ports: clk_in, rst_n (async, active-low), slow_clk, run_sw, step_btn, halt_req,
//        cpu_ce, running, state (00 HALT, 01 RUN, 10 STEP), step_count.
// Optional macro CPU_STEP_BREAKPOINT_EN adds pc, bp_addr, bp_valid, bp_hit.
module cpu_step_controller #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
    parameter int          CNT_WIDTH       = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 slow_clk,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic                 halt_req,
`ifdef CPU_STEP_BREAKPOINT_EN
    input  logic [7:0]           pc,
    input  logic [7:0]           bp_addr,
    input  logic                 bp_valid,
    output logic                 bp_hit,
`endif
    output logic                 cpu_ce,
    output logic                 running,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] step_count
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } st_t;

    st_t         cur;
    logic        slow_s1, slow_s2, slow_s3;
    logic        run_s1, run_s2;
    logic        btn_s1, btn_s2;
    logic        btn_acc;
    logic [15:0] db_cnt;
    logic        step_ev;
    logic        tick;
    logic        run_go;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
        end else begin
            slow_s1 <= slow_clk;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
            run_s1  <= run_sw;
            run_s2  <= run_s1;
            btn_s1  <= step_btn;
            btn_s2  <= btn_s1;
        end
    end

    // slow_s3 is only an edge-detect delay of slow_s2
    assign tick = slow_s2 & ~slow_s3;

    // Accepted level moves only after an unbroken run of differing samples
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            btn_acc <= 1'b0;
            db_cnt  <= 16'd0;
            step_ev <= 1'b0;
        end else begin
            step_ev <= 1'b0;
            if (btn_s2 == btn_acc) begin
                db_cnt <= 16'd0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                db_cnt  <= 16'd0;
                btn_acc <= btn_s2;
                step_ev <= btn_s2;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

`ifdef CPU_STEP_BREAKPOINT_EN
    // A pending breakpoint keeps the core parked until a step clears it
    assign run_go = run_s2 & ~halt_req & ~bp_hit;
`else
    assign run_go = run_s2 & ~halt_req;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= HALT;
            cpu_ce     <= 1'b0;
            running    <= 1'b0;
            step_count <= '0;
`ifdef CPU_STEP_BREAKPOINT_EN
            bp_hit     <= 1'b0;
`endif
        end else begin
            cpu_ce <= 1'b0;
            unique case (cur)
                HALT: begin
                    if (run_go) begin
                        cur     <= RUN;
                        running <= 1'b1;
`ifdef CPU_STEP_BREAKPOINT_EN
                        bp_hit  <= 1'b0;
`endif
                    end else if (step_ev) begin
                        cur    <= STEP;
`ifdef CPU_STEP_BREAKPOINT_EN
                        bp_hit <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (halt_req || !run_s2) begin
                        cur     <= HALT;
                        running <= 1'b0;
                    end else if (tick) begin
`ifdef CPU_STEP_BREAKPOINT_EN
                        if (bp_valid && (pc == bp_addr)) begin
                            cur     <= HALT;
                            running <= 1'b0;
                            bp_hit  <= 1'b1;
                        end else begin
                            cpu_ce     <= 1'b1;
                            step_count <= step_count + 1'b1;
                        end
`else
                        cpu_ce     <= 1'b1;
                        step_count <= step_count + 1'b1;
`endif
                    end
                end
                STEP: begin
                    // halt_req is deliberately ignored so a step always completes
                    if (tick) begin
                        cpu_ce     <= 1'b1;
                        step_count <= step_count + 1'b1;
                        cur        <= HALT;
                    end
                end
                default: begin
                    cur     <= HALT;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur;

endmodule
